cam_i2c_sched: RTL and testbench
================================

// Module: cam_i2c_sched
// PURPOSE
//  Scheduler that shares the single camera I2C command engine between two requesters:
//  the init-ROM sequencer (strict priority) and a runtime register-update queue (e.g. exposure/gain writes).
//  Presents the engine's en/end handshake to each requester and enforces a minimum bus-idle gap between commands.
//  Sits between the camera init controller / user logic and the I2C command engine.
// PARAMETERS
//  CMD_W          32      command word width ({id, reg_hi, reg_lo, data}, passed through untouched)
//  FIFO_DEPTH     4       runtime update queue depth (power of 2, >=2)
//  GAP_CYCLES     2       idle cycles forced between end of one command and next cmd_en_o (>=1)
//  TIMEOUT_CYCLES 200000  cycles in RUN before abort (used only with CAM_I2C_SCHED_TIMEOUT_EN)
// PORTS
//  clk_i        in   1              system clock
//  rst_ni       in   1              asynchronous active-low reset
//  init_req_i   in   1              init sequencer requests; held high with stable data until init_ack_o
//  init_data_i  in   CMD_W          init command word
//  init_ack_o   out  1              1-cycle pulse: init command finished (or aborted)
//  upd_valid_i  in   1              runtime update word valid
//  upd_data_i   in   CMD_W          runtime update word
//  upd_ready_o  out  1              queue not full; push = upd_valid_i & upd_ready_o
//  upd_level_o  out  log2(DEPTH)+1  queue occupancy
//  cmd_en_o     out  1              to engine: held high for whole command
//  cmd_data_o   out  CMD_W          to engine: registered, stable while cmd_en_o high
//  cmd_end_i    in   1              from engine: 1-cycle completion pulse
//  busy_o       out  1              state != IDLE
//  timeout_o    out  1              1-cycle pulse on abort (tied 0 without macro)
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, queue empty, all outputs 0 except upd_ready_o=1.
//  FSM:
//   IDLE  -> GRANT when init_req_i=1 or queue non-empty; init wins when both present.
//   GRANT (1 cycle): latch owner, load cmd_data_o (init_data_i or queue head); pop if owner=update.
//   RUN: cmd_en_o=1; on cmd_end_i -> cmd_en_o=0, init_ack_o pulse if owner=init, -> GAP.
//   GAP: count GAP_CYCLES, then -> IDLE. First new cmd_en_o >= GAP_CYCLES+2 cycles after cmd_end_i.
//  Init lock: while init_req_i=1, or within 1 cycle after init_ack_o, queue is not granted.
//   So a back-to-back ROM sequence is never interleaved; updates keep queuing meanwhile.
//  cmd_end_i outside RUN is ignored. init_req_i dropping mid-RUN does not abort; no ack is issued if it is already low.
//  Queue: push and pop in the same cycle are allowed, level unchanged.
//   Full -> upd_ready_o=0, word dropped at the source side (producer must hold).
//   Pointers wrap modulo FIFO_DEPTH.
//  Owner encoding 1 bit; cmd_data_o holds last value when idle.
//  Reset mid-RUN: cmd_en_o drops immediately (async); the engine must tolerate an en abort.
// CONFIGURATION
//  CAM_I2C_SCHED_TIMEOUT_EN defined:
//   RUN counter; at TIMEOUT_CYCLES without cmd_end_i -> cmd_en_o=0, timeout_o pulse.
//   init_ack_o still pulses if owner=init (sequencer never hangs), -> GAP.
//  Undefined: no counter, RUN waits indefinitely, timeout_o tied 0.
// STRUCTURE
//  Shared package/header cam_i2c_pkg: CMD_W, state encodings (IDLE/GRANT/RUN/GAP), owner codes.
//  Sub-module cam_i2c_cmd_fifo: synchronous FIFO with level, full/empty, same-cycle push/pop.
// TESTING
//  1 Reset: rst_ni=0 mid-RUN -> cmd_en_o=0 same cycle; after release upd_ready_o=1, upd_level_o=0, busy_o=0.
//  2 Single init: init_req_i=1, data=32'h42_30_12_80; engine end after 10 cycles
//    -> cmd_data_o=32'h42301280 in RUN; init_ack_o one pulse; next grant >= GAP_CYCLES+2 later.
//  3 Priority/lock: push 2 updates, then hold init_req_i for 3 commands
//    -> all 3 init first, then updates in push order; upd_level_o 2->1->0.
//  4 Queue full: push 5 words with no engine end -> upd_ready_o=0 after 4, level=4.
//    Push+pop in the same cycle keeps the level.
//  5 Spurious end: cmd_end_i pulse in IDLE/GAP -> no state change, no ack.
//  6 Timeout (macro on, TIMEOUT_CYCLES=50): no cmd_end_i -> cmd_en_o falls at cycle 50 with timeout_o
//    and init_ack_o pulses. Macro off: cmd_en_o stays high.

Source files
------------

// File: rtl/cam_i2c_pkg.sv
// Shared types for the camera I2C command scheduler: FSM states, owner codes,
// default command width and the sizing helper for the shared cycle counter.
package cam_i2c_pkg;

    localparam int unsigned DEF_CMD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_RUN   = 2'd2,
        ST_GAP   = 2'd3
    } sched_state_e;

    typedef enum logic {
        OWN_INIT = 1'b0,
        OWN_UPD  = 1'b1
    } owner_e;

    // Counter holds values up to max(gap, timeout) - 1.
    function automatic int unsigned cnt_width(input int unsigned gap, input int unsigned tmo);
        int unsigned m;
        m = (gap > tmo) ? gap : tmo;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/cam_i2c_cmd_fifo.sv
// Runtime register-update queue: synchronous FIFO with occupancy level,
// full/empty flags and same-cycle push/pop.
module cam_i2c_cmd_fifo
    import cam_i2c_pkg::*;
#(
    parameter int unsigned W     = DEF_CMD_W,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [W-1:0]  data_i,
    input  logic          pop_i,
    output logic [W-1:0]  head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q;
    logic          do_push, do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      level_q <= level_q + 1'b1;
            else if (do_pop && !do_push) level_q <= level_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/cam_i2c_sched.sv
// Shares the camera I2C command engine between the init sequencer (priority) and the
// runtime update queue. Optional RUN watchdog: define CAM_I2C_SCHED_TIMEOUT_EN.
module cam_i2c_sched
    import cam_i2c_pkg::*;
#(
    parameter int unsigned CMD_W          = DEF_CMD_W,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 200000,
    localparam int unsigned LVL_W         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             init_req_i,
    input  logic [CMD_W-1:0] init_data_i,
    output logic             init_ack_o,
    input  logic             upd_valid_i,
    input  logic [CMD_W-1:0] upd_data_i,
    output logic             upd_ready_o,
    output logic [LVL_W-1:0] upd_level_o,
    output logic             cmd_en_o,
    output logic [CMD_W-1:0] cmd_data_o,
    input  logic             cmd_end_i,
    output logic             busy_o,
    output logic             timeout_o
);

    localparam int unsigned CNT_W = cnt_width(GAP_CYCLES, TIMEOUT_CYCLES);

    sched_state_e     state_q, state_d;
    owner_e           owner_q, owner_d;
    logic [CMD_W-1:0] cmd_data_q, cmd_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ack_q, ack_d, ack_dly_q;
    logic             upd_lock, fifo_pop;
    logic [CMD_W-1:0] fifo_head;
    logic             fifo_full, fifo_empty;
    logic [LVL_W-1:0] fifo_level;
`ifdef CAM_I2C_SCHED_TIMEOUT_EN
    logic             to_q, to_d;
`endif

    cam_i2c_cmd_fifo #(
        .W     (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (upd_valid_i),
        .data_i  (upd_data_i),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_INIT;
            cmd_data_q <= '0;
            cnt_q      <= '0;
            ack_q      <= 1'b0;
            ack_dly_q  <= 1'b0;
`ifdef CAM_I2C_SCHED_TIMEOUT_EN
            to_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cmd_data_q <= cmd_data_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            ack_dly_q  <= ack_q;
`ifdef CAM_I2C_SCHED_TIMEOUT_EN
            to_q       <= to_d;
`endif
        end
    end

    // Updates stay locked out while a ROM sequence is active or has just been acked,
    // so the sequencer gets one cycle to raise its next request.
    assign upd_lock = init_req_i | ack_q | ack_dly_q;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cmd_data_d = cmd_data_q;
        cnt_d      = '0;
        ack_d      = 1'b0;
        fifo_pop   = 1'b0;
`ifdef CAM_I2C_SCHED_TIMEOUT_EN
        to_d       = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (init_req_i) begin
                    state_d = ST_GRANT;
                    owner_d = OWN_INIT;
                end else if (!fifo_empty && !upd_lock) begin
                    state_d = ST_GRANT;
                    owner_d = OWN_UPD;
                end
            end
            ST_GRANT: begin
                cmd_data_d = (owner_q == OWN_UPD) ? fifo_head : init_data_i;
                fifo_pop   = (owner_q == OWN_UPD);
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                if (cmd_end_i) begin
                    state_d = ST_GAP;
                    ack_d   = (owner_q == OWN_INIT) && init_req_i;
                end
`ifdef CAM_I2C_SCHED_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_GAP;
                    ack_d   = (owner_q == OWN_INIT) && init_req_i;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) state_d = ST_IDLE;
                else                                  cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_en_o    = (state_q == ST_RUN);
        busy_o      = (state_q != ST_IDLE);
        cmd_data_o  = cmd_data_q;
        init_ack_o  = ack_q;
        upd_ready_o = ~fifo_full;
        upd_level_o = fifo_level;
`ifdef CAM_I2C_SCHED_TIMEOUT_EN
        timeout_o   = to_q;
`else
        timeout_o   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_cam_i2c_sched.sv
// Bench for cam_i2c_sched: directed scenarios plus random traffic against a cycle-timed
// model of the scheduling rules (grant two cycles after decision, GAP idle, init priority/lock).
module tb_cam_i2c_sched;

    localparam int DEPTH = 4;
    localparam int GAP   = 2;
    localparam int TMO   = 50;

    logic        clk = 1'b0;
    logic        rst_ni, init_req_i, upd_valid_i, cmd_end_i;
    logic [31:0] init_data_i, upd_data_i, cmd_data_o;
    logic        init_ack_o, upd_ready_o, cmd_en_o, busy_o, timeout_o;
    logic [2:0]  upd_level_o;

    always #5 clk = ~clk;

    cam_i2c_sched #(
        .CMD_W          (32),
        .FIFO_DEPTH     (DEPTH),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .init_req_i  (init_req_i),
        .init_data_i (init_data_i),
        .init_ack_o  (init_ack_o),
        .upd_valid_i (upd_valid_i),
        .upd_data_i  (upd_data_i),
        .upd_ready_o (upd_ready_o),
        .upd_level_o (upd_level_o),
        .cmd_en_o    (cmd_en_o),
        .cmd_data_o  (cmd_data_o),
        .cmd_end_i   (cmd_end_i),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    bit          chk_en = 1'b1;
    logic [31:0] mq[$];
    logic [31:0] exp_data;
    bit          m_run, m_pend, m_own_init, m_push;
    logic [31:0] m_push_w;
    int          m_start, m_idle_from, m_ack_at, m_lock_last, m_gap_end;

    always @(negedge clk) begin
        if (!rst_ni || !chk_en) begin
            mq.delete();
            m_run = 0; m_pend = 0; m_push = 0;
            m_idle_from = cyc; m_ack_at = -1; m_lock_last = -100; m_gap_end = -1;
        end else begin
            if (m_push) mq.push_back(m_push_w);
            if (m_pend && cyc == m_start) begin
                m_pend = 0;
                m_run  = 1;
                if (!m_own_init) void'(mq.pop_front());
            end
            chk("cmd_en", cmd_en_o, m_run);
            if (m_run) chk("cmd_data", cmd_data_o, exp_data);
            chk("busy", busy_o, m_pend || m_run || cyc <= m_gap_end);
            chk("init_ack", init_ack_o, cyc == m_ack_at);
            chk("level", upd_level_o, mq.size());
            chk("ready", upd_ready_o, mq.size() < DEPTH);
            chk("timeout", timeout_o, 0);
            if (m_run && cmd_end_i) begin
                m_run       = 0;
                m_gap_end   = cyc + GAP;
                m_idle_from = cyc + GAP + 1;
                if (m_own_init && init_req_i) begin
                    m_ack_at    = cyc + 1;
                    m_lock_last = cyc + 2;
                end
            end
            if (!m_run && !m_pend && cyc >= m_idle_from) begin
                if (init_req_i) begin
                    m_pend = 1; m_start = cyc + 2; m_own_init = 1; exp_data = init_data_i;
                end else if (mq.size() > 0 && cyc > m_lock_last) begin
                    m_pend = 1; m_start = cyc + 2; m_own_init = 0; exp_data = mq[0];
                end
            end
            m_push   = upd_valid_i && (mq.size() < DEPTH);
            m_push_w = upd_data_i;
        end
    end

    // ---------------- stimulus ----------------
    bit eng_auto = 0, seq_auto = 0, prod_auto = 0, seq_stop = 0, prod_stop = 0;
    int en_cnt = 0, lat = 5, seq_left = 0;

    task automatic step();
        bit acc;
        acc = upd_valid_i && upd_ready_o;
        @(posedge clk); #2;
        cmd_end_i = 1'b0;
        if (eng_auto) begin
            if (cmd_en_o) begin
                en_cnt++;
                if (en_cnt >= lat) begin
                    cmd_end_i = 1'b1;
                    en_cnt    = 0;
                    lat       = $urandom_range(1, 12);
                end
            end else begin
                en_cnt = 0;
                if ($urandom_range(0, 15) == 0) cmd_end_i = 1'b1;
            end
        end
        if (seq_auto) begin
            if (init_req_i) begin
                if (init_ack_o) begin
                    seq_left--;
                    if (seq_left == 0) init_req_i = 1'b0;
                    else               init_data_i = $urandom;
                end
            end else if (!seq_stop && $urandom_range(0, 39) == 0) begin
                init_req_i  = 1'b1;
                init_data_i = $urandom;
                seq_left    = $urandom_range(1, 3);
            end
        end
        if (prod_auto && (acc || !upd_valid_i)) begin
            upd_valid_i = !prod_stop && ($urandom_range(0, 2) == 0);
            upd_data_i  = $urandom;
        end
    endtask

    task automatic wait_rise(input int maxc, output int n);
        n = 0;
        while (!cmd_en_o && n < maxc) begin
            step();
            n++;
        end
        chk("wait_cmd_en", cmd_en_o, 1);
    endtask

    task automatic push_word(input logic [31:0] w);
        int k;
        k = 0;
        upd_valid_i = 1'b1;
        upd_data_i  = w;
        while (!upd_ready_o && k < 50) begin
            step();
            k++;
        end
        step();
    endtask

    task automatic drain(input int maxc);
        int k;
        k = 0;
        while ((init_req_i || upd_valid_i || upd_level_o != 0 || busy_o) && k < maxc) begin
            step();
            k++;
        end
        chk("drain_idle", busy_o || upd_level_o != 0, 0);
    endtask

    initial begin
        int n, e;
        rst_ni = 0; init_req_i = 0; upd_valid_i = 0; cmd_end_i = 0;
        init_data_i = '0; upd_data_i = '0;
        repeat (3) @(posedge clk);
        #2 rst_ni = 1;
        #1;
        chk("rst_cmd_en", cmd_en_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ready", upd_ready_o, 1);
        chk("rst_level", upd_level_o, 0);
        chk("rst_ack", init_ack_o, 0);
        chk("rst_cmd_data", cmd_data_o, 32'h0);

        // reset in the middle of a command
        init_req_i = 1; init_data_i = 32'hA5A5_0001;
        wait_rise(10, n);
        step(); step();
        rst_ni = 0;
        #1;
        chk("midrun_rst_cmd_en", cmd_en_o, 0);
        chk("midrun_rst_busy", busy_o, 0);
        init_req_i = 0;
        step(); step();
        rst_ni = 1;
        #1;
        chk("release_ready", upd_ready_o, 1);
        chk("release_level", upd_level_o, 0);
        chk("release_busy", busy_o, 0);

        // single init, then priority over queued updates for a 3-command ROM burst
        init_req_i = 1; init_data_i = 32'h42_30_12_80;
        wait_rise(10, n);
        chk("init_data", cmd_data_o, 32'h4230_1280);
        upd_valid_i = 1; upd_data_i = 32'h1111_0001;
        step();
        upd_data_i = 32'h1111_0002;
        step();
        upd_valid_i = 0;
        repeat (7) step();
        cmd_end_i = 1; e = cyc;
        step();
        chk("init_ack_1", init_ack_o, 1);
        chk("level_held_2", upd_level_o, 2);
        init_data_i = 32'h4230_1300;
        step();
        chk("init_ack_pulse", init_ack_o, 0);
        wait_rise(20, n);
        chk("gap_min", (cyc - e) >= GAP + 2, 1);
        chk("init_2_data", cmd_data_o, 32'h4230_1300);
        step(); step();
        cmd_end_i = 1;
        step();
        chk("init_ack_2", init_ack_o, 1);
        init_data_i = 32'h4230_1400;
        wait_rise(20, n);
        chk("init_3_data", cmd_data_o, 32'h4230_1400);
        step();
        cmd_end_i = 1;
        step();
        chk("init_ack_3", init_ack_o, 1);
        init_req_i = 0;
        wait_rise(20, n);
        chk("upd_1_data", cmd_data_o, 32'h1111_0001);
        chk("upd_1_level", upd_level_o, 1);
        step();
        cmd_end_i = 1;
        step();
        wait_rise(20, n);
        chk("upd_2_data", cmd_data_o, 32'h1111_0002);
        chk("upd_2_level", upd_level_o, 0);
        step();
        cmd_end_i = 1;
        step();

        // init request withdrawn mid-command: no ack
        repeat (4) step();
        init_req_i = 1; init_data_i = 32'hD0D0_0001;
        wait_rise(10, n);
        step();
        init_req_i = 0;
        step();
        cmd_end_i = 1;
        step();
        chk("drop_no_ack", init_ack_o, 0);
        repeat (4) step();

        // spurious engine end in IDLE and GAP
        cmd_end_i = 1;
        step();
        chk("spur_idle_busy", busy_o, 0);
        chk("spur_idle_ack", init_ack_o, 0);
        init_req_i = 1; init_data_i = 32'h5A5A_0001;
        wait_rise(10, n);
        cmd_end_i = 1;
        step();
        init_req_i = 0;
        cmd_end_i = 1;
        step();
        chk("spur_gap_ack", init_ack_o, 0);
        chk("spur_gap_busy", busy_o, 1);
        step();
        chk("spur_gap_done", busy_o, 0);

        // queue full while the engine holds the first popped word
        for (int i = 0; i < 5; i++) push_word(32'hF000_0000 + i);
        upd_valid_i = 1; upd_data_i = 32'hF000_0005;
        chk("full_level", upd_level_o, 4);
        chk("full_ready", upd_ready_o, 0);
        step(); step();
        chk("full_hold_level", upd_level_o, 4);
        chk("full_cmd_en", cmd_en_o, 1);
        chk("full_first_word", cmd_data_o, 32'hF000_0000);
        cmd_end_i = 1;
        push_word(32'hF000_0005);
        upd_valid_i = 0;
        eng_auto = 1;
        drain(400);

        // random traffic
        seq_auto = 1; prod_auto = 1;
        repeat (3000) step();
        seq_stop = 1; prod_stop = 1;
        drain(2000);
        seq_auto = 0; prod_auto = 0; eng_auto = 0;
        repeat (4) step();

        // engine never answers
        chk_en = 0;
        init_req_i = 1; init_data_i = 32'h7E7E_0001;
        wait_rise(10, n);
`ifdef CAM_I2C_SCHED_TIMEOUT_EN
        n = 0;
        while (cmd_en_o && n < 200) begin
            n++;
            step();
        end
        chk("timeout_len", n, TMO);
        chk("timeout_pulse", timeout_o, 1);
        chk("timeout_ack", init_ack_o, 1);
        init_req_i = 0;
`else
        repeat (100) step();
        chk("no_timeout_en", cmd_en_o, 1);
        chk("no_timeout_pulse", timeout_o, 0);
        cmd_end_i = 1;
        step();
        init_req_i = 0;
`endif
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
